// File: rtl/stopwatch_control_if.sv
// stopwatch_control_if: button, feedback and counter-chain control signals of the stopwatch control stage
interface stopwatch_control_if;
   logic btn_start, btn_clear, btn_mode, all_zero;
   logic tick, up_down, clear, running, done;
   modport master(output btn_start, btn_clear, btn_mode, all_zero, input tick, up_down, clear, running, done);
   modport slave(input btn_start, btn_clear, btn_mode, all_zero, output tick, up_down, clear, running, done);
endinterface

// File: rtl/stopwatch_control.sv
// stopwatch_control: button debounce, IDLE/RUN/PAUSE/DONE sequencing and tick prescaler for the BCD digit chain
module stopwatch_control #(
   parameter int TICK_DIV        = 1_000_000,
   parameter int DEBOUNCE_CYCLES = 1_000_000
) (
   input logic clk,
   input logic rst,
   stopwatch_control_if.slave sw
);
   localparam int DW = $clog2(DEBOUNCE_CYCLES);
   localparam int PW = $clog2(TICK_DIV);
   typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;
   state_t state, nxt;
   logic [2:0] raw, press;
   logic [PW-1:0] presc;
   logic has_ticked, ud_q, tick_q;
   logic pc, ps, pm, tick_ev, stop;
   assign raw = {sw.btn_mode, sw.btn_start, sw.btn_clear};
   // index 0 = clear, 1 = start, 2 = mode
   for (genvar i = 0; i < 3; i++) begin : g_btn
      logic s1, s2, lvl, lvl_d, p;
      logic [DW-1:0] cnt;
      always_ff @(posedge clk)
         if (rst) begin
            {s1, s2, lvl, lvl_d, p} <= '0;
            cnt <= '0;
         end else begin
            s1 <= raw[i];
            s2 <= s1;
            lvl_d <= lvl;
            p <= lvl & ~lvl_d;
            if (s2 == lvl) cnt <= '0;
            else if (cnt == DW'(DEBOUNCE_CYCLES - 1)) begin
               lvl <= s2;
               cnt <= '0;
            end else cnt <= cnt + 1'b1;
         end
      assign press[i] = p;
   end
   assign pc = press[0];
   assign ps = press[1] & ~pc;
   assign pm = press[2] & ~press[0] & ~press[1];
   // a start/clear press on the wrap cycle takes precedence over the tick
   assign tick_ev = state == RUN && !pc && !ps && presc == PW'(TICK_DIV - 1);
   assign stop = tick_ev && !ud_q && sw.all_zero && has_ticked;
   always_ff @(posedge clk)
      if (rst) begin
         state <= IDLE;
         presc <= '0;
         has_ticked <= 1'b0;
         ud_q <= 1'b1;
         tick_q <= 1'b0;
      end else begin
         state <= nxt;
         tick_q <= tick_ev & ~stop;
         has_ticked <= state == IDLE ? 1'b0 : has_ticked | (tick_ev & ~stop);
         presc <= (state == IDLE || pc) ? '0 : (state == RUN && !ps) ? (tick_ev ? '0 : presc + 1'b1) : presc;
         ud_q <= ud_q ^ (state == IDLE && pm);
      end
   always_comb begin
      nxt = pc ? IDLE :
            ps ? (state == RUN ? PAUSE : state == DONE ? DONE : RUN) :
            stop ? DONE : state;
   end
   always_comb begin
      sw.clear = state == IDLE;
      sw.running = state == RUN;
      sw.done = state == DONE;
      sw.tick = tick_q;
      sw.up_down = ud_q;
   end
endmodule
